// File: rtl/pitch_game_pkg.sv
// Shared types and constants for the pitch-to-height path.
package pitch_game_pkg;

    typedef logic [9:0] height_t;

    localparam height_t Y_MIN     = 10'd16;
    localparam height_t Y_MAX     = 10'd457;  // 16 + 7*63
    localparam height_t DEFAULT_Y = 10'd240;

    // Limit a raw height estimate to the playable band.
    function automatic height_t clamp_height(input height_t h);
        if (h < Y_MIN) begin
            return Y_MIN;
        end
        if (h > Y_MAX) begin
            return Y_MAX;
        end
        return h;
    endfunction

endpackage

// File: rtl/player_height_filter_if.sv
// Sample/frame strobes in, smoothed and slewed heights out.
interface player_height_filter_if;

    pitch_game_pkg::height_t height_in;
    logic                    height_valid;
    logic                    frame_tick;
    pitch_game_pkg::height_t target_y;
    pitch_game_pkg::height_t player_y;
    logic                    moving;
    logic                    stale;

    // Producer of height samples and frame ticks, consumer of the results.
    modport master (
        output height_in, height_valid, frame_tick,
        input  target_y, player_y, moving, stale
    );

    // The filter itself.
    modport slave (
        input  height_in, height_valid, frame_tick,
        output target_y, player_y, moving, stale
    );

endinterface

// File: rtl/moving_avg.sv
// N_TAPS-deep moving average of 10-bit heights using a running sum.
module moving_avg
    import pitch_game_pkg::*;
#(
    parameter int unsigned N_TAPS = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    input  height_t in_data,
    output height_t avg
);

    localparam int unsigned SHIFT = $clog2(N_TAPS);
    localparam int unsigned SW    = 10 + SHIFT;

    height_t          taps_q [N_TAPS];
    logic [SHIFT-1:0] wr_ptr_q;
    logic [SW-1:0]    sum_q;

    // Replace the oldest entry and adjust the running sum; pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_TAPS); i++) begin
                taps_q[i] <= DEFAULT_Y;
            end
            wr_ptr_q <= '0;
            sum_q    <= SW'(DEFAULT_Y) << SHIFT;
        end else if (in_valid) begin
            taps_q[wr_ptr_q] <= in_data;
            wr_ptr_q         <= wr_ptr_q + SHIFT'(1);
            sum_q            <= sum_q + SW'(in_data) - SW'(taps_q[wr_ptr_q]);
        end
    end

    // Truncating divide by the tap count.
    always_comb begin
        avg = height_t'(sum_q >> SHIFT);
    end

endmodule

// File: rtl/player_height_filter.sv
// Smooths raw height estimates into a target and slews the player toward it per frame.
module player_height_filter
    import pitch_game_pkg::*;
#(
    parameter int unsigned N_TAPS       = 4,
    parameter int unsigned MAX_STEP     = 4,
    parameter int unsigned STALE_FRAMES = 30
) (
    input logic                   clk,
    input logic                   reset,
    player_height_filter_if.slave bus
);

    localparam int unsigned CW = $clog2(STALE_FRAMES + 1);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_FRAMES);

    height_t          clamped;
    height_t          avg;
    logic [CW-1:0]    stale_cnt_q;
    logic             stale;
    height_t          target_q;
    height_t          player_q;
    height_t          slew_y;
    logic             moving_q;
    logic signed [10:0] diff;
    logic [10:0]      mag;

    // Clamp the incoming estimate before it enters the averager.
    always_comb begin
        clamped = clamp_height(bus.height_in);
    end

    moving_avg #(
        .N_TAPS (N_TAPS)
    ) u_moving_avg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.height_valid),
        .in_data  (clamped),
        .avg      (avg)
    );

    // Frame-tick silence counter; a valid sample clears it even on a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            stale_cnt_q <= STALE_MAX;
        end else if (bus.height_valid) begin
            stale_cnt_q <= '0;
        end else if (bus.frame_tick && (stale_cnt_q != STALE_MAX)) begin
            stale_cnt_q <= stale_cnt_q + CW'(1);
        end
    end

    assign stale = (stale_cnt_q == STALE_MAX);

    // Step toward the target by at most MAX_STEP, snapping when within range.
    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, player_q});
        mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= 11'(MAX_STEP)) begin
            slew_y = target_q;
        end else if (diff[10]) begin
            slew_y = player_q - 10'(MAX_STEP);
        end else begin
            slew_y = player_q + 10'(MAX_STEP);
        end
    end

    // Target, player position and motion flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= DEFAULT_Y;
            player_q <= DEFAULT_Y;
            moving_q <= 1'b0;
        end else begin
            target_q <= stale ? DEFAULT_Y : avg;
            if (bus.frame_tick) begin
                player_q <= slew_y;
            end
            moving_q <= (player_q != target_q);
        end
    end

    assign bus.target_y = target_q;
    assign bus.player_y = player_q;
    assign bus.moving   = moving_q;
    assign bus.stale    = stale;

endmodule
